// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipeline register enable/clear generator with debug halt/step and stats
//
// Purpose: drives every inter-stage pipeline register of the N-stage CPU.
//   Combines load-use stalls, taken-branch flushes and memory-busy freezes
//   into per-stage enable/clear vectors. Adds a registered debug halt mode
//   with rising-edge single-step, and saturating event counters.
//
// Ports:
//   clk          - main clock, all state on posedge
//   rst          - synchronous active-high reset
//   reg_stall    - load-use hazard at HZ_STAGE
//   branch_taken - taken branch at BR_STAGE
//   mem_busy     - memory not ready, whole pipeline waits
//   debug_en     - request halt mode
//   debug_step   - step request (level, rising edge counts)
//   stage_en     - per-register enable
//   stage_rst    - per-register synchronous clear (bubble insert)
//   halted       - 1 while in HALT
//   stall_cnt    - applied load-use stall cycles
//   flush_cnt    - applied branch flushes
//   busy_cnt     - applied mem_busy freeze cycles

module pipe_ctrl_unit #(
    parameter int STAGES   = 5,
    parameter int HZ_STAGE = 1,
    parameter int BR_STAGE = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_stall,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              debug_en,
    input  logic              debug_step,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_rst,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  busy_cnt
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    logic             state_q, state_d;
    logic             step_pending_q, step_pending_d;
    logic             step_prev_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, busy_cnt_q;

    logic held;
    logic apply_busy, apply_stall, apply_flush;

    // A pending step releases the hold for exactly one real pipeline cycle.
    assign held = (state_q == ST_HALT) && !step_pending_q;

    assign apply_busy  = !rst && !held && mem_busy;
    assign apply_stall = !rst && !held && !mem_busy && reg_stall;
    assign apply_flush = !rst && !held && !mem_busy && !reg_stall && branch_taken;

    always_comb begin
        stage_en  = '1;
        stage_rst = '0;
        if (rst) begin
            stage_rst = '1;
        end else if (held || mem_busy) begin
            stage_en = '0;
        end else if (reg_stall) begin
            // Freeze everything up to the hazard stage, bubble the next one.
            for (int i = 0; i <= HZ_STAGE; i++) begin
                stage_en[i] = 1'b0;
            end
            stage_rst[HZ_STAGE+1] = 1'b1;
        end else if (branch_taken) begin
            // PC keeps its enable so it loads the branch target.
            for (int i = 1; i <= BR_STAGE; i++) begin
                stage_rst[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = debug_en ? ST_HALT : ST_RUN;
        step_pending_d = step_pending_q;
        if (state_q == ST_HALT && !debug_en) begin
            step_pending_d = 1'b0;
        end else if (step_pending_q) begin
            // A step stalled by mem_busy stays pending; extra edges are dropped.
            if (!mem_busy) begin
                step_pending_d = 1'b0;
            end
        end else if (state_q == ST_HALT && debug_step && !step_prev_q) begin
            step_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            step_pending_q <= 1'b0;
            step_prev_q    <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            busy_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
            step_prev_q    <= debug_step;
            if (apply_stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (apply_flush && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (apply_busy && !(&busy_cnt_q)) begin
                busy_cnt_q <= busy_cnt_q + CNT_W'(1);
            end
        end
    end

    assign halted    = (state_q == ST_HALT);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised pipeline control unit for the N-stage MIPS pipelined CPU. It generates per-stage register enable and reset vectors from three sources: load-use hazard stalls, taken-branch flushes and memory-busy freezes. It adds a registered debug halt/single-step mode and saturating performance counters. It sits beside the instruction decoder and drives every inter-stage pipeline register.

## Interface
Parameters:
- STAGES, 5, number of pipeline registers; index 0 = IF (PC), 1 = ID, 2 = EXE, 3 = MEM, 4 = WB.
- HZ_STAGE, 1, stage in which the load-use hazard is detected; must satisfy 0 ≤ HZ_STAGE ≤ STAGES-2.
- BR_STAGE, 1, stage in which a branch resolves; must satisfy 1 ≤ BR_STAGE ≤ STAGES-1.
- CNT_W, 16, width of each performance counter.

Ports (clk and rst are already decided):
- clk, in, 1, main clock; all state updates on posedge.
- rst, in, 1, synchronous, active-high reset.
- reg_stall, in, 1, load-use hazard present at HZ_STAGE.
- branch_taken, in, 1, taken branch currently at BR_STAGE.
- mem_busy, in, 1, data/instruction memory not ready; the whole pipeline must wait.
- debug_en, in, 1, request halt mode.
- debug_step, in, 1, step request, level signal; its rising edge counts.
- stage_en, out, STAGES, per-register enable.
- stage_rst, out, STAGES, per-register synchronous clear (inserts a bubble).
- halted, out, 1, registered; 1 while in HALT mode.
- stall_cnt, out, CNT_W, load-use stall cycles applied.
- flush_cnt, out, CNT_W, branch flushes applied.
- busy_cnt, out, CNT_W, mem_busy freeze cycles applied.

## Operation
Defaults: stage_en all 1, stage_rst all 0.

Combinational priority, highest first:
1. **rst:** stage_rst all 1, stage_en all 1.
2. **Held:** halted=1 and step_pending=0. stage_en all 0.
3. **mem_busy:** stage_en all 0, no resets.
4. **reg_stall:** stage_en[0..HZ_STAGE]=0, stage_rst[HZ_STAGE+1]=1.
5. **branch_taken:** stage_rst[1..BR_STAGE]=1. stage_en[0] stays 1 so the PC loads the target.

Rules:
- reg_stall wins over branch_taken. The branch re-resolves after the stall clears.

Debug FSM, registered, two states:
- **RUN → HALT:** when debug_en is sampled high.
- **HALT → RUN:** when debug_en is sampled low. step_pending clears at the same time.
- **Edge detect:** step_prev <= debug_step every cycle.
- **Setting step_pending:** in HALT, debug_step & ~step_prev sets step_pending.
- **Step cycle:** while step_pending=1, priorities 3–5 apply normally.
- **Clearing step_pending:** it clears at the end of that cycle only if mem_busy=0. A step therefore advances exactly one real pipeline cycle.
- **Extra edges:** a rising edge while step_pending=1 is ignored, not queued.

"Applied cycle" means: not rst, not Held, and the named rule is the winning branch of the priority list.

Counters:
- stall_cnt increments on each applied cycle of rule 4.
- flush_cnt increments on each applied cycle of rule 5.
- busy_cnt increments on each applied cycle of rule 3.
- Each counter saturates at 2^CNT_W-1; no wrap.

Reset values:
- halted=0, step_pending=0, step_prev=0.
- All counters 0.
- stage_en/stage_rst as in rule 1.

## Timing
- stage_en and stage_rst are combinational from the inputs and the current state, with zero latency. They take effect at the same posedge.
- halted becomes 1 one cycle after debug_en is first sampled high. The cycle in which debug_en rises still advances normally.
- A debug_step rising edge sampled at posedge k makes cycle k+1 the step cycle. That assumes mem_busy=0; otherwise the step is deferred until mem_busy falls.
- Counters update at the posedge ending the applied cycle and are visible the next cycle.
- **rst mid-step or mid-halt:** returns to RUN and clears step_pending and the counters in one cycle.
- **debug_en held high across rst:** the FSM re-enters HALT the cycle after rst deasserts.

## Test plan
All scenarios use defaults (STAGES=5, HZ_STAGE=1, BR_STAGE=1).
- **Load-use stall:** reg_stall=1 for 1 cycle -> stage_en=5'b11100, stage_rst=5'b00100; stall_cnt 0→1.
- **Stall vs branch:** reg_stall=1 with branch_taken=1 -> stall pattern only; flush_cnt unchanged. Next cycle with branch_taken=1 alone -> stage_rst=5'b00010, stage_en=5'b11111; flush_cnt=1.
- **Memory freeze:** mem_busy=1 for 3 cycles with reg_stall=1 -> stage_en=0 and stage_rst=0 for all 3 cycles; busy_cnt=3, stall_cnt=0.
- **Debug stepping:**
  - Raise debug_en -> halted=1 next cycle; stage_en=0 thereafter.
  - Pulse debug_step once -> exactly one cycle with stage_en=5'b11111.
  - Hold debug_step high 10 cycles -> still only one step.
- **Step during busy:** in HALT, step edge with mem_busy=1 for 2 cycles -> the pipeline stays frozen (busy_cnt +2). It advances exactly once in the cycle mem_busy falls, then holds.
- **Saturation and reset:** with CNT_W=2, 5 stall cycles -> stall_cnt=3. Assert rst during HALT -> halted=0, all counters 0, stage_rst=5'b11111.
